// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the UART program loader.
package program_loader_pkg;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    WAIT_HDR,
    GET_CNT,
    GET_DATA,
    GET_CSUM,
    DONE,
    ERROR
  } load_state_t;
endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: synchronized input, mid-bit sampling, glitch rejection on the start bit.
module uart_rx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t   state, next;
  logic        sync1, rx_s, rx_d;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick_half, tick_bit;

  assign tick_half = (cnt == 16'(HALF - 1));
  assign tick_bit  = (cnt == 16'(CLKS_PER_BIT - 1));
  assign byte_data = shreg;

  always_comb begin
    next = state;
    case (state)
      RX_IDLE:  if (rx_d && !rx_s) next = RX_START;
      RX_START: if (tick_half) next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_bit && bit_idx == 3'd7) next = RX_STOP;
      RX_STOP:  if (tick_bit) next = RX_WAIT;
      // a low stop bit leaves the line low; hold off until it returns high
      RX_WAIT:  if (rx_s) next = RX_IDLE;
      default:  next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      rx_s       <= sync1;
      rx_d       <= rx_s;
      state      <= next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state != next || (state == RX_DATA && tick_bit)) cnt <= '0;
      else cnt <= cnt + 16'd1;
      if (state == RX_DATA && tick_bit) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && tick_bit) begin
        if (rx_s) byte_valid <= 1'b1;
        else frame_err <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/program_loader.sv
// Loads a checksummed instruction image from UART into instruction memory, holding the CPU in reset until done.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);
  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;
  load_state_t state, next;
  logic [7:0]  word_count, word_idx, csum;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        word_done;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign word_done = byte_valid && (byte_idx == 2'd3);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_reset = (state != DONE);

  always_comb begin
    next = state;
    case (state)
      WAIT_HDR: if (byte_valid && byte_data == HDR_BYTE) next = GET_CNT;
      GET_CNT:  if (frame_err) next = ERROR;
                else if (byte_valid) next = GET_DATA;
      // count 0 encodes 256 words: word_count-1 wraps to 255
      GET_DATA: if (frame_err) next = ERROR;
                else if (word_done && word_idx == word_count - 8'd1) next = GET_CSUM;
      GET_CSUM: if (frame_err) next = ERROR;
                else if (byte_valid) next = (byte_data == csum) ? DONE : ERROR;
      DONE:     next = DONE;
      ERROR:    if (byte_valid && byte_data == HDR_BYTE) next = GET_CNT;
      default:  next = WAIT_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_HDR;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      word_buf   <= '0;
    end else begin
      state   <= next;
      imem_we <= 1'b0;
      if ((state == WAIT_HDR || state == ERROR) && next == GET_CNT) begin
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end
      if (state == GET_CNT && byte_valid) word_count <= byte_data;
      if (state == GET_DATA && byte_valid) begin
        csum     <= csum ^ byte_data;
        byte_idx <= byte_idx + 2'd1;
        word_buf <= {word_buf[15:0], byte_data};
        if (byte_idx == 2'd3) begin
          imem_we    <= 1'b1;
          imem_addr  <= {22'd0, word_idx, 2'b00};
          imem_wdata <= {word_buf, byte_data};
          word_idx   <= word_idx + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench: frame-level model predicts writes and final status for each loaded image.
module tb_program_loader;
  localparam int CPB      = 16;
  localparam int CPB_FAST = 8;

  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, rx_fast = 1'b1;
  logic        imem_we, cpu_reset, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic        f_we, f_cpu_reset, f_done, f_error;
  logic [31:0] f_addr, f_wdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$], exp_f_q[$], got, w0;
  logic [31:0] pay_q[$];
  logic [31:0] last_addr = '0, last_wdata = '0, last_f_addr = '0;
  int          checks = 0, errors = 0, f_writes = 0;
  logic        reset_prev = 1'b1;

  always #5 clk = ~clk;

  program_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  // long 256-word image runs on a faster-baud instance to keep the run short
  program_loader #(.CLKS_PER_BIT(CPB_FAST)) dut_fast (
    .clk(clk), .reset(reset), .rx(rx_fast), .imem_we(f_we), .imem_addr(f_addr),
    .imem_wdata(f_wdata), .cpu_reset(f_cpu_reset), .done(f_done), .error(f_error)
  );

  always @(negedge clk) begin
    if (reset && reset_prev) begin
      checks++;
      if ({imem_we, imem_addr, imem_wdata, cpu_reset, done, error, f_we, f_cpu_reset, f_done, f_error}
          !== {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state we=%b addr=%h wdata=%h cpu_reset=%b done=%b error=%b fast_we=%b required 0 0 0 1 0 0 0",
                 imem_we, imem_addr, imem_wdata, cpu_reset, done, error, f_we);
      end
    end else if (!reset) begin
      checks++;
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected addr=%h data=%h required no write", imem_addr, imem_wdata);
        end else begin
          got = exp_q.pop_front();
          if (imem_addr !== got.addr || imem_wdata !== got.data) begin
            errors++;
            $display("FAIL write addr=%h data=%h required addr=%h data=%h", imem_addr, imem_wdata, got.addr, got.data);
          end
        end
      end else if (imem_addr !== last_addr || imem_wdata !== last_wdata) begin
        errors++;
        $display("FAIL hold addr=%h data=%h required addr=%h data=%h", imem_addr, imem_wdata, last_addr, last_wdata);
      end
      if (f_we) begin
        checks++;
        f_writes++;
        last_f_addr = f_addr;
        if (exp_f_q.size() == 0) begin
          errors++;
          $display("FAIL fast_write_unexpected addr=%h data=%h required no write", f_addr, f_wdata);
        end else begin
          got = exp_f_q.pop_front();
          if (f_addr !== got.addr || f_wdata !== got.data) begin
            errors++;
            $display("FAIL fast_write addr=%h data=%h required addr=%h data=%h", f_addr, f_wdata, got.addr, got.data);
          end
        end
      end
    end
    reset_prev = reset;
    last_addr  = imem_addr;
    last_wdata = imem_wdata;
  end

  function automatic logic [7:0] pay_byte(input int k);
    logic [31:0] w;
    w = pay_q[k / 4];
    return w[8 * (3 - k % 4) +: 8];
  endfunction

  function automatic logic [7:0] payload_xor();
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 4 * pay_q.size(); k++) x ^= pay_byte(k);
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit fast);
    int cpb;
    logic [9:0] frame;
    cpb   = fast ? CPB_FAST : CPB;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (fast) rx_fast = frame[i];
      else rx = frame[i];
      repeat (cpb) @(negedge clk);
    end
    if (fast) rx_fast = 1'b1;
    else rx = 1'b1;
    if (!stop_ok) repeat (cpb) @(negedge clk);
  endtask

  // Model: words 0..N-1 land at 4*i unless a framing error cuts the frame before the word completes.
  task automatic run_frame(input logic [7:0] n, input bit bad_csum, input int bad_byte,
                           input bit fast, input bit ignored);
    int  nw;
    wr_t w;
    nw = (n == 8'd0) ? 256 : int'(n);
    if (!ignored)
      for (int i = 0; i < nw; i++)
        if (bad_byte < 0 || 4 * i + 3 < bad_byte) begin
          w.addr = 32'(4 * i);
          w.data = pay_q[i];
          if (fast) exp_f_q.push_back(w);
          else exp_q.push_back(w);
        end
    send_byte(8'hA5, 1'b1, fast);
    send_byte(n, 1'b1, fast);
    for (int k = 0; k < 4 * nw; k++) begin
      send_byte(pay_byte(k), k != bad_byte, fast);
      if (k == bad_byte) return;
    end
    send_byte(payload_xor() ^ (bad_csum ? 8'hFF : 8'h00), 1'b1, fast);
  endtask

  task automatic check_status(input string name, input bit fast, input bit exp_done, input bit exp_err);
    logic d, e, c;
    int   pend;
    repeat (4) @(negedge clk);
    d    = fast ? f_done : done;
    e    = fast ? f_error : error;
    c    = fast ? f_cpu_reset : cpu_reset;
    pend = fast ? exp_f_q.size() : exp_q.size();
    checks++;
    if (d !== exp_done || e !== exp_err || c !== ~exp_done) begin
      errors++;
      $display("FAIL %s_status done=%b error=%b cpu_reset=%b required %b %b %b",
               name, d, e, c, exp_done, exp_err, ~exp_done);
    end
    checks++;
    if (pend != 0) begin
      errors++;
      $display("FAIL %s_writes pending=%0d required 0", name, pend);
    end
  endtask

  task automatic do_reset();
    rx      = 1'b1;
    rx_fast = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    pay_q = '{32'h20080005};
    checks++;
    if (payload_xor() !== 8'h2D) begin
      errors++;
      $display("FAIL model_xor got=%h required 2d", payload_xor());
    end
    run_frame(8'd1, 1'b0, -1, 1'b0, 1'b0);
    check_status("single_word", 1'b0, 1'b1, 1'b0);
    checks++;
    if (last_addr !== 32'h0 || last_wdata !== 32'h20080005) begin
      errors++;
      $display("FAIL single_word_value addr=%h data=%h required 0 20080005", last_addr, last_wdata);
    end
    pay_q = '{32'h0BADF00D};
    run_frame(8'd1, 1'b0, -1, 1'b0, 1'b1);
    check_status("done_sticky", 1'b0, 1'b1, 1'b0);

    do_reset();
    pay_q = '{32'h11223344, 32'h55667788};
    run_frame(8'd2, 1'b1, -1, 1'b0, 1'b0);
    check_status("bad_csum", 1'b0, 1'b0, 1'b1);
    checks++;
    if (last_addr !== 32'h4 || last_wdata !== 32'h55667788) begin
      errors++;
      $display("FAIL bad_csum_last addr=%h data=%h required 4 55667788", last_addr, last_wdata);
    end
    pay_q = '{32'hDEADBEEF};
    run_frame(8'd1, 1'b0, -1, 1'b0, 1'b0);
    check_status("recover", 1'b0, 1'b1, 1'b0);

    do_reset();
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_status("garbage", 1'b0, 1'b0, 1'b0);
    pay_q = '{32'h12345678};
    run_frame(8'd1, 1'b0, -1, 1'b0, 1'b0);
    check_status("after_garbage", 1'b0, 1'b1, 1'b0);

    do_reset();
    pay_q = '{32'hA1B2C3D4, 32'h01020304};
    run_frame(8'd2, 1'b0, 2, 1'b0, 1'b0);
    check_status("stop_err", 1'b0, 1'b0, 1'b1);

    do_reset();
    pay_q  = '{32'hCAFEF00D, 32'h0BADBEEF};
    w0.addr = 32'h0;
    w0.data = 32'hCAFEF00D;
    exp_q.push_back(w0);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(pay_byte(k), 1'b1, 1'b0);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    do_reset();
    checks++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset addr=%h data=%h cpu_reset=%b done=%b error=%b required 0 0 1 0 0",
               imem_addr, imem_wdata, cpu_reset, done, error);
    end
    check_status("abort", 1'b0, 1'b0, 1'b0);
    pay_q = '{32'h00C0FFEE};
    run_frame(8'd1, 1'b0, -1, 1'b0, 1'b0);
    check_status("reload", 1'b0, 1'b1, 1'b0);
    checks++;
    if (last_addr !== 32'h0 || last_wdata !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL reload_value addr=%h data=%h required 0 00c0ffee", last_addr, last_wdata);
    end

    do_reset();
    pay_q.delete();
    for (int i = 0; i < 256; i++) pay_q.push_back($urandom);
    run_frame(8'd0, 1'b0, -1, 1'b1, 1'b0);
    check_status("full_256", 1'b1, 1'b1, 1'b0);
    checks++;
    if (last_f_addr !== 32'h3FC || f_writes !== 256) begin
      errors++;
      $display("FAIL full_256_end last_addr=%h writes=%0d required 3fc 256", last_f_addr, f_writes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
